// File: rtl/alu_cmd_issuer_if.sv
// Command / ALU / response bundle between the issuer and its surroundings.
// The slave modport is the issuer's view; master is the environment's view.
interface alu_cmd_issuer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [3:0]            cmd_opcode;
    logic [DATA_WIDTH-1:0] cmd_a;
    logic [DATA_WIDTH-1:0] cmd_b;
    logic [DATA_WIDTH-1:0] alu_operand_a;
    logic [DATA_WIDTH-1:0] alu_operand_b;
    logic [3:0]            alu_opcode;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_err;
    logic [7:0]            cmd_count;
    logic [7:0]            err_count;

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_result, rsp_ready,
        output cmd_ready, alu_operand_a, alu_operand_b, alu_opcode,
               rsp_valid, rsp_data, rsp_err, cmd_count, err_count
    );

    modport master (
        output cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_result, rsp_ready,
        input  cmd_ready, alu_operand_a, alu_operand_b, alu_opcode,
               rsp_valid, rsp_data, rsp_err, cmd_count, err_count
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Issues one add/subtract command at a time to an external registered ALU
// and returns its result; unsupported opcodes are answered with an error
// response without touching the ALU.
module alu_cmd_issuer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    alu_cmd_issuer_if.slave   bus
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESPOND
    } state_t;

    state_t                state_q;
    logic                  cmd_ready_q;
    logic [DATA_WIDTH-1:0] alu_a_q;
    logic [DATA_WIDTH-1:0] alu_b_q;
    logic [3:0]            alu_op_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  rsp_err_q;
    logic [7:0]            cmd_count_q;
    logic [7:0]            err_count_q;

    logic                  op_supported;

    // Opcode decode of the offered command.
    always_comb begin
        op_supported = (bus.cmd_opcode == OP_ADD) || (bus.cmd_opcode == OP_SUB);
    end

    // Command FSM with all outputs registered; reset overrides any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= OP_ADD;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            cmd_count_q <= '0;
            err_count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        cmd_count_q <= cmd_count_q + 8'd1;
                        cmd_ready_q <= 1'b0;
                        if (op_supported) begin
                            alu_a_q  <= bus.cmd_a;
                            alu_b_q  <= bus.cmd_b;
                            alu_op_q <= bus.cmd_opcode;
                            state_q  <= ISSUE;
                        end else begin
                            rsp_data_q  <= '0;
                            rsp_err_q   <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            if (err_count_q != 8'hFF) begin
                                err_count_q <= err_count_q + 8'd1;
                            end
                            state_q <= RESPOND;
                        end
                    end
                end
                ISSUE: begin
                    // ALU samples the operands on this edge.
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    rsp_data_q  <= bus.alu_result;
                    rsp_err_q   <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESPOND;
                end
                RESPOND: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.alu_operand_a = alu_a_q;
    assign bus.alu_operand_b = alu_b_q;
    assign bus.alu_opcode    = alu_op_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_data      = rsp_data_q;
    assign bus.rsp_err       = rsp_err_q;
    assign bus.cmd_count     = cmd_count_q;
    assign bus.err_count     = err_count_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: directed cases plus randomized
// commands compared against a transaction-level reference model.
module tb_alu_cmd_issuer;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // Reference model state (per-transaction view).
    logic [7:0]    exp_cmd;
    logic [7:0]    exp_err;
    logic [DW-1:0] last_a;
    logic [DW-1:0] last_b;
    logic [3:0]    last_op;

    alu_cmd_issuer_if #(.DATA_WIDTH(DW)) bus ();

    alu_cmd_issuer #(.DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // External registered ALU: one-cycle latency.
    always_ff @(posedge clk) begin
        if (bus.alu_opcode == 4'd1) bus.alu_result <= bus.alu_operand_a - bus.alu_operand_b;
        else                        bus.alu_result <= bus.alu_operand_a + bus.alu_operand_b;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_cmd = '0;
        exp_err = '0;
        last_a  = '0;
        last_b  = '0;
        last_op = '0;
    endtask

    task automatic chk_alu(input string tag);
        chk({tag, "_alu_a"},  32'(bus.alu_operand_a), 32'(last_a));
        chk({tag, "_alu_b"},  32'(bus.alu_operand_b), 32'(last_b));
        chk({tag, "_alu_op"}, 32'(bus.alu_opcode),    32'(last_op));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_rsp_data"},  32'(bus.rsp_data),  32'd0);
        chk({tag, "_rsp_err"},   32'(bus.rsp_err),   32'd0);
        chk({tag, "_cmd_count"}, 32'(bus.cmd_count), 32'd0);
        chk({tag, "_err_count"}, 32'(bus.err_count), 32'd0);
        chk_alu(tag);
    endtask

    // One full command transaction, with `hold` cycles of response backpressure.
    task automatic run_cmd(input logic [3:0] op, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input int hold);
        bit            sup;
        int            n;
        logic [DW-1:0] exp_d;
        sup = (op == 4'd0) || (op == 4'd1);
        if (!sup)            exp_d = '0;
        else if (op == 4'd0) exp_d = a + b;
        else                 exp_d = a - b;

        chk("ready_before_accept", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = op;
        bus.cmd_a      = a;
        bus.cmd_b      = b;
        tick();
        exp_cmd = exp_cmd + 8'd1;
        if (!sup && exp_err != 8'hFF) exp_err = exp_err + 8'd1;
        if (sup) begin
            last_a  = a;
            last_b  = b;
            last_op = op;
        end
        // Keep offering junk commands; they must be ignored while busy.
        bus.cmd_opcode = 4'($urandom_range(0, 15));
        bus.cmd_a      = DW'($urandom);
        bus.cmd_b      = DW'($urandom);
        chk("ready_low_busy", 32'(bus.cmd_ready), 32'd0);
        chk_alu("after_accept");

        n = 1;
        while (bus.rsp_valid !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk("rsp_latency", 32'(n), sup ? 32'd3 : 32'd1);
        chk("rsp_data",    32'(bus.rsp_data),  32'(exp_d));
        chk("rsp_err",     32'(bus.rsp_err),   32'(!sup));
        chk("cmd_count",   32'(bus.cmd_count), 32'(exp_cmd));
        chk("err_count",   32'(bus.err_count), 32'(exp_err));
        chk_alu("respond");

        bus.rsp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid",     32'(bus.rsp_valid), 32'd1);
            chk("hold_data",      32'(bus.rsp_data),  32'(exp_d));
            chk("hold_err",       32'(bus.rsp_err),   32'(!sup));
            chk("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            chk("hold_cmd_count", 32'(bus.cmd_count), 32'(exp_cmd));
        end

        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b0;
        chk("post_hs_valid",     32'(bus.rsp_valid), 32'd0);
        chk("post_hs_ready",     32'(bus.cmd_ready), 32'd1);
        chk("post_hs_data",      32'(bus.rsp_data),  32'(exp_d));
        chk("post_hs_err",       32'(bus.rsp_err),   32'(!sup));
        chk("post_hs_cmd_count", 32'(bus.cmd_count), 32'(exp_cmd));
    endtask

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_opcode = '0;
        bus.cmd_a      = '0;
        bus.cmd_b      = '0;
        bus.rsp_ready  = 1'b0;
        model_reset();

        // Reset values
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        chk_reset_state("reset");

        // Add with wrap: 200 + 100 = 44
        run_cmd(4'b0000, 8'd200, 8'd100, 0);
        chk("add_literal", 32'(bus.rsp_data), 32'd44);
        // Subtract with borrow wrap: 5 - 10 = 251
        run_cmd(4'b0001, 8'd5, 8'd10, 0);
        chk("sub_literal", 32'(bus.rsp_data), 32'd251);
        // Unsupported opcode
        run_cmd(4'b0111, 8'd3, 8'd4, 0);
        chk("unsup_err_count", 32'(bus.err_count), 32'd1);
        // Backpressure for 5 cycles
        run_cmd(4'b0000, 8'd17, 8'd25, 5);

        // Randomized commands
        for (int i = 0; i < 40; i++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 1))
                                             : 4'($urandom_range(0, 15));
            run_cmd(op, DW'($urandom), DW'($urandom), int'($urandom_range(0, 3)));
        end

        // Reset while in CAPTURE
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = 4'd0;
        bus.cmd_a      = 8'd9;
        bus.cmd_b      = 8'd9;
        tick();               // accept -> ISSUE
        bus.cmd_valid = 1'b0;
        tick();               // ISSUE -> CAPTURE
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        chk_reset_state("mid_op_reset");
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("no_stale_rsp", 32'(bus.rsp_valid), 32'd0);
        end

        // Reset has priority over an offered command
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = 4'd5;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.cmd_valid = 1'b0;
        chk_reset_state("rst_priority");

        // 256 accepts wrap cmd_count to 0
        for (int i = 0; i < 256; i++) begin
            run_cmd(4'($urandom_range(0, 15)), DW'($urandom), DW'($urandom), 0);
        end
        chk("cmd_count_wrap", 32'(bus.cmd_count), 32'd0);

        // 300 unsupported commands saturate err_count
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 300; i++) begin
            run_cmd(4'($urandom_range(2, 15)), DW'($urandom), DW'($urandom), 0);
        end
        chk("err_count_sat",   32'(bus.err_count), 32'd255);
        chk("cmd_count_after", 32'(bus.cmd_count), 32'd44);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
